// File: rtl/ps2_teclado_rx.sv
// PS/2 keyboard receiver: synchronises and deglitches ps2c/ps2d, deserialises
// 11-bit device-to-host frames, checks odd parity and the stop bit, filters
// break sequences and holds each make code as a level flag until ack.
// Ports: clk/reset (sync, active-high); ps2c/ps2d async PS/2 lines; ack clears
// new_data/parity_err/overrun; data_teclado/new_data present the code;
// parity_err/overrun are sticky error flags; busy is high while a frame is in flight.
module ps2_teclado_rx #(
    parameter int FILTER_LEN   = 8,
    parameter int TIMEOUT_CYC  = 200000,
    parameter bit IGNORE_BREAK = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    input  logic       ack,
    output logic [7:0] data_teclado,
    output logic       new_data,
    output logic       parity_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, RX, CHECK} state_t;

    // Input synchronisers and clock deglitch filter
    logic                  c_meta, c_sync, d_meta, d_sync;
    logic [FILTER_LEN-1:0] filt;
    logic                  f_clk;
    logic                  fall_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            c_meta <= 1'b1;
            c_sync <= 1'b1;
            d_meta <= 1'b1;
            d_sync <= 1'b1;
            filt   <= '1;
            f_clk  <= 1'b1;
        end else begin
            c_meta <= ps2c;
            c_sync <= c_meta;
            d_meta <= ps2d;
            d_sync <= d_meta;
            filt   <= {filt[FILTER_LEN-2:0], c_sync};
            if (&filt)
                f_clk <= 1'b1;
            else if (~|filt)
                f_clk <= 1'b0;
        end
    end

    // High in the cycle where the filtered clock is about to drop; the data
    // line is sampled in this same cycle.
    assign fall_tick = f_clk & ~|filt;

    // Receive FSM and output registers
    state_t     state_q, state_n;
    logic [9:0] sreg_q, sreg_n;
    logic [3:0] cnt_q, cnt_n;
    logic [TW-1:0] tmo_q, tmo_n;
    logic       brk_q, brk_n;
    logic [7:0] data_q, data_n;
    logic       nd_q, nd_n;
    logic       pe_q, pe_n;
    logic       ov_q, ov_n;

    logic       frame_ok;
    logic [7:0] code;

    assign code     = sreg_q[7:0];
    // Odd parity over data+parity bit, and stop bit must be 1
    assign frame_ok = (^sreg_q[8:0]) & sreg_q[9];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            brk_q   <= 1'b0;
            data_q  <= 8'h00;
            nd_q    <= 1'b0;
            pe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_n;
            sreg_q  <= sreg_n;
            cnt_q   <= cnt_n;
            tmo_q   <= tmo_n;
            brk_q   <= brk_n;
            data_q  <= data_n;
            nd_q    <= nd_n;
            pe_q    <= pe_n;
            ov_q    <= ov_n;
        end
    end

    always_comb begin
        state_n = state_q;
        sreg_n  = sreg_q;
        cnt_n   = cnt_q;
        tmo_n   = tmo_q;
        brk_n   = brk_q;
        data_n  = data_q;
        nd_n    = nd_q;
        pe_n    = pe_q;
        ov_n    = ov_q;

        // ack clears flags first; anything CHECK does below takes priority
        if (ack) begin
            nd_n = 1'b0;
            pe_n = 1'b0;
            ov_n = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (fall_tick && !d_sync) begin
                    state_n = RX;
                    cnt_n   = '0;
                    tmo_n   = '0;
                end
            end
            RX: begin
                if (fall_tick) begin
                    sreg_n = {d_sync, sreg_q[9:1]};
                    cnt_n  = cnt_q + 4'd1;
                    tmo_n  = '0;
                    if (cnt_q == 4'd9)
                        state_n = CHECK;
                end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
                    // Line went quiet mid-frame: drop it silently
                    state_n = IDLE;
                    tmo_n   = '0;
                end else begin
                    tmo_n = tmo_q + TW'(1);
                end
            end
            CHECK: begin
                state_n = IDLE;
                if (!frame_ok) begin
                    pe_n = 1'b1;
                end else if (IGNORE_BREAK && code == 8'hF0) begin
                    brk_n = 1'b1;
                end else if (brk_q) begin
                    brk_n = 1'b0;
                end else begin
                    data_n = code;
                    nd_n   = 1'b1;
                    if (nd_q && !ack)
                        ov_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign data_teclado = data_q;
    assign new_data     = nd_q;
    assign parity_err   = pe_q;
    assign overrun      = ov_q;
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_teclado_rx.sv
// Bench for ps2_teclado_rx: directed scenarios followed by random frames.
// Expected outputs come from a frame-level model pushed into a queue; a
// negedge monitor pops and compares whenever the receiver presents a change.
module tb_ps2_teclado_rx;

    localparam int FILTER_LEN = 8;
    localparam int TIMEOUT    = 1000;
    localparam int HP         = 40;                  // PS/2 half bit period, clk cycles
    localparam int LAT        = 2 + FILTER_LEN + 2;  // clk edges: drive of stop fall -> outputs

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ps2c = 1'b1;
    logic       ps2d = 1'b1;
    logic       ack = 1'b0;
    logic [7:0] data_teclado;
    logic       new_data, parity_err, overrun, busy;

    ps2_teclado_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT),
        .IGNORE_BREAK(1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .ack         (ack),
        .data_teclado(data_teclado),
        .new_data    (new_data),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference model state (frame-level)
    logic [7:0] m_data = 8'h00;
    logic       m_nd = 1'b0, m_pe = 1'b0, m_ov = 1'b0, m_brk = 1'b0;

    typedef struct {
        logic [7:0] data;
        logic       nd, pe, ov;
        int         stamp;
    } exp_t;
    exp_t q[$];

    task automatic push_exp(input int stamp);
        exp_t e;
        e.data = m_data; e.nd = m_nd; e.pe = m_pe; e.ov = m_ov; e.stamp = stamp;
        q.push_back(e);
    endtask

    task automatic model_frame(input logic [7:0] code, input bit bad, input bit ack_c, input int stamp);
        if (ack_c) begin m_nd = 0; m_pe = 0; m_ov = 0; end
        if (bad) begin
            m_pe = 1;
            push_exp(stamp);
        end else if (code == 8'hF0) begin
            m_brk = 1;
        end else if (m_brk) begin
            m_brk = 0;
        end else begin
            if (m_nd) m_ov = 1;
            m_nd = 1;
            m_data = code;
            push_exp(stamp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] code, input bit bad_par, input bit bad_stop,
                              input bit ack_c);
        logic [10:0] fr;
        logic par;
        par = ~(^code);
        if (bad_par) par = ~par;
        fr = {~bad_stop, par, code, 1'b0};
        for (int i = 0; i < 11; i++) begin
            ps2d = fr[i];
            wait_cyc(HP);
            ps2c = 1'b0;
            if (i == 10) begin
                model_frame(code, bad_par | bad_stop, ack_c, cyc);
                if (ack_c) begin
                    wait_cyc(LAT - 1);   // ack lands on the edge that leaves CHECK
                    ack = 1'b1;
                    wait_cyc(1);
                    ack = 1'b0;
                    wait_cyc(HP - LAT);
                end else begin
                    wait_cyc(HP);
                end
            end else begin
                wait_cyc(HP);
            end
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
        wait_cyc(2 * HP);
    endtask

    // Start bit plus nbits-1 data bits, then the line is left idle
    task automatic send_partial(input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2d = (i == 0) ? 1'b0 : i[0];
            wait_cyc(HP);
            ps2c = 1'b0;
            wait_cyc(HP);
            ps2c = 1'b1;
        end
        ps2d = 1'b1;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        wait_cyc(1);
        ack = 1'b0;
        m_nd = 0; m_pe = 0; m_ov = 0;
        wait_cyc(2);
    endtask

    // Monitor: any visible change of the presented code/flags is one event
    logic [7:0] p_data = 8'h00;
    logic       p_nd = 0, p_pe = 0, p_ov = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if ((new_data && !p_nd) || (data_teclado != p_data) ||
                (parity_err && !p_pe) || (overrun && !p_ov)) begin
                if (q.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("data_teclado", data_teclado, e.data);
                    chk("new_data", new_data, e.nd);
                    chk("parity_err", parity_err, e.pe);
                    chk("overrun", overrun, e.ov);
                    chk("latency", cyc - e.stamp, LAT);
                end
            end else if (q.size() > 0 && (cyc - q[0].stamp) > LAT + 20) begin
                chk("output_timeout", 0, 1);
                void'(q.pop_front());
            end
        end
        p_data = data_teclado;
        p_nd   = new_data;
        p_pe   = parity_err;
        p_ov   = overrun;
    end

    initial begin
        int seen_busy;
        logic [7:0] code;
        bit bad_p, bad_s;

        wait_cyc(5);
        reset = 1'b0;
        wait_cyc(2);
        chk("rst_data", data_teclado, 8'h00);
        chk("rst_new_data", new_data, 0);
        chk("rst_parity_err", parity_err, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_busy", busy, 0);

        // Basic make code and ack
        send_frame(8'h1C, 0, 0, 0);
        do_ack();
        chk("ack_new_data", new_data, 0);
        chk("ack_data_held", data_teclado, 8'h1C);

        // Break sequence suppressed, then next make code
        send_frame(8'hF0, 0, 0, 0);
        send_frame(8'h1C, 0, 0, 0);
        chk("brk_new_data", new_data, 0);
        chk("brk_data", data_teclado, 8'h1C);
        send_frame(8'h32, 0, 0, 0);
        do_ack();

        // Bad parity, bad stop
        send_frame(8'h1C, 1, 0, 0);
        chk("perr_new_data", new_data, 0);
        do_ack();
        send_frame(8'h1C, 0, 1, 0);
        do_ack();
        chk("perr_cleared", parity_err, 0);

        // Partial frame times out
        send_partial(4);
        wait_cyc(TIMEOUT + 100);
        chk("timeout_busy", busy, 0);
        send_frame(8'h32, 0, 0, 0);
        do_ack();

        // Overrun, then ack coinciding with CHECK
        send_frame(8'h1C, 0, 0, 0);
        send_frame(8'h32, 0, 0, 0);
        send_frame(8'h45, 0, 0, 1);
        do_ack();

        // Short clock glitch must not start a frame
        ps2d = 1'b0;
        ps2c = 1'b0;
        wait_cyc(FILTER_LEN - 2);
        ps2c = 1'b1;
        seen_busy = 0;
        for (int i = 0; i < 30; i++) begin
            wait_cyc(1);
            if (busy) seen_busy = 1;
        end
        chk("glitch_busy", seen_busy, 0);
        ps2d = 1'b1;
        wait_cyc(20);

        // Reset mid-frame
        send_frame(8'h5A, 0, 0, 0);
        send_partial(5);
        reset = 1'b1;
        wait_cyc(2);
        reset = 1'b0;
        m_data = 8'h00; m_nd = 0; m_pe = 0; m_ov = 0; m_brk = 0;
        wait_cyc(1);
        chk("midrst_data", data_teclado, 8'h00);
        chk("midrst_new_data", new_data, 0);
        chk("midrst_overrun", overrun, 0);
        chk("midrst_busy", busy, 0);
        wait_cyc(20);
        send_frame(8'h1C, 0, 0, 0);

        // Random frames
        for (int n = 0; n < 20; n++) begin
            code  = ($urandom_range(0, 99) < 15) ? 8'hF0 : 8'($urandom);
            bad_p = ($urandom_range(0, 99) < 10);
            bad_s = !bad_p && ($urandom_range(0, 99) < 5);
            // Make every outcome visible as a change on the outputs
            if ((bad_p || bad_s) && m_pe) do_ack();
            if (!(bad_p || bad_s) && code != 8'hF0 && !m_brk && m_nd && code == m_data) do_ack();
            send_frame(code, bad_p, bad_s, 0);
            if ($urandom_range(0, 99) < 40) begin
                do_ack();
                chk("rnd_ack_new_data", new_data, 0);
            end
        end

        wait_cyc(LAT + 40);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_teclado_rx.md
Name: ps2_teclado_rx

Overview:
PS/2 keyboard receiver that supplies the keyboard data and new-data flag to the input register bank, in place of the fixed constants (data = 8'hff, new_data = 0) in the current top level.
- Synchronises and deglitches the PS/2 clock and data lines.
- Deserialises 11-bit device-to-host frames and checks odd parity and the stop bit.
- Filters key-release (break) sequences.
- Presents each make code as a level flag held until the PicoBlaze acknowledges it.

Parameters:
FILTER_LEN, 8, number of consecutive identical synchronised ps2c samples required to change the filtered clock level.
TIMEOUT_CYC, 200000, clk cycles without a falling edge after which a partial frame is discarded (2 ms at 100 MHz).
IGNORE_BREAK, 1, when 1, F0 and the code following it are suppressed; when 0, every valid code is presented.

Ports:
clk  in  1  system clock; single clock domain.
reset  in  1  synchronous, active-high reset.
ps2c  in  1  PS/2 clock line; asynchronous.
ps2d  in  1  PS/2 data line; asynchronous.
ack  in  1  one-cycle pulse from the PicoBlaze output port; clears new_data, parity_err and overrun.
data_teclado  out  8  last accepted scan code.
new_data  out  1  level; a code is waiting to be read.
parity_err  out  1  sticky; a frame was rejected for bad parity or bad stop bit.
overrun  out  1  sticky; a new code replaced one that had not been acknowledged.
busy  out  1  high while a frame is being received (state RX or CHECK).

Behaviour:
- Reset values: data_teclado = 8'h00; new_data, parity_err, overrun, busy = 0.
- Reset internal state: filtered clock = 1, synchroniser flip-flops = 1, shift register = 0, bit count = 0, timeout counter = 0, break_pend = 0, state = IDLE.
- Reset mid-frame aborts the frame with no output.
- Input path: two-flip-flop synchroniser on ps2c and on ps2d, followed by a FILTER_LEN-deep shift register on ps2c.
  - Filtered clock goes to 1 when all samples are 1 and to 0 when all samples are 0; otherwise it holds.
- fall_tick: one-cycle pulse when the filtered clock goes from 1 to 0. Data is sampled from synchronised ps2d in that same cycle.
- IDLE:
  - fall_tick with ps2d = 0 (start bit) -> RX; bit count = 0; timeout counter cleared.
  - fall_tick with ps2d = 1 -> ignored, remain in IDLE.
- RX:
  - Each fall_tick shifts ps2d in LSB-first into a 10-bit register (8 data bits, parity, stop), increments the bit count and clears the timeout counter.
  - The fall_tick that makes the count 10 -> CHECK.
  - Timeout counter increments every cycle without a fall_tick; reaching TIMEOUT_CYC -> IDLE, frame discarded, no flag changes.
- CHECK: one cycle, then always -> IDLE.
  - Valid frame: XOR of the 8 data bits and the parity bit = 1, and stop bit = 1.
  - Invalid frame: parity_err <= 1; data_teclado and new_data unchanged.
  - Valid code F0 with IGNORE_BREAK = 1: break_pend <= 1; no output.
  - Any other valid code with break_pend = 1: break_pend <= 0; code discarded.
  - Otherwise: data_teclado <= code, new_data <= 1; overrun <= 1 if new_data was already 1.
- E0 (extended prefix) is treated as an ordinary code. Sequence E0 F0 xx therefore presents only E0.
- Latency: fall_tick of the stop bit in cycle N -> state = CHECK in N+1 -> data_teclado and new_data valid from N+2.
- ack:
  - Clears new_data, parity_err and overrun on the next edge.
  - If ack coincides with CHECK accepting a code, the new code wins: new_data = 1 and data_teclado updated. overrun is set only if new_data was 1 and ack was 0.
  - ack has no effect on the receive FSM.
- busy = 1 in RX and CHECK.

Test Plan:
- Frame 0x1C (bits 0,0,1,1,1,0,0,0; parity 0; stop 1) at a 12.5 kHz PS/2 clock -> data_teclado = 8'h1C, new_data = 1 exactly 2 cycles after the stop-bit fall_tick; pulse ack -> new_data = 0, data_teclado stays 8'h1C.
- Frames F0 then 1C with IGNORE_BREAK = 1 -> new_data remains 0 throughout and data_teclado unchanged. Then frame 0x32 -> data_teclado = 8'h32, new_data = 1.
- Frame 0x1C with parity bit 1 -> parity_err = 1, new_data = 0. Repeat with correct parity but stop bit 0 -> parity_err = 1. ack -> parity_err = 0.
- With TIMEOUT_CYC = 1000: start bit plus 3 data bits, then idle for 1000 cycles -> busy = 0. Then a full 0x32 frame -> data_teclado = 8'h32, new_data = 1, parity_err = 0.
- Frames 0x1C then 0x32 with no ack -> data_teclado = 8'h32, overrun = 1. ack in the same cycle as CHECK of a third frame 0x45 -> data_teclado = 8'h45, new_data = 1, overrun = 0.
- Glitch test: ps2c pulsed low for FILTER_LEN-2 cycles while IDLE with ps2d = 0 -> no fall_tick, busy stays 0. Assert reset in the middle of a frame -> all outputs return to reset values, and the next full frame is received correctly.
